// File: rtl/lr_sc_responder.sv
// ============================================================================
// lr_sc_responder : per-hart LR/SC reservation tracker and SC verdict responder
// Revision 1.0
// ============================================================================
`default_nettype none

module lr_sc_responder #(
  parameter int XLEN           = 32,
  parameter int NUM_HARTS      = 2,
  parameter int HART_W         = 1,
  parameter int GRANULE_BITS   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [HART_W-1:0]    i_req_hart,
  input  logic [1:0]           i_req_op,
  input  logic [XLEN-1:0]      i_req_addr,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [HART_W-1:0]    o_rsp_hart,
  output logic [1:0]           o_rsp_op,
  output logic                 o_rsp_sc_fail,
  input  logic                 i_snoop_valid,
  input  logic [XLEN-1:0]      i_snoop_addr,
  output logic [NUM_HARTS-1:0] o_res_valid
);

  localparam int GRAN_W = XLEN - GRANULE_BITS;
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] c_OP_LOAD  = 2'b00;
  localparam logic [1:0] c_OP_STORE = 2'b01;
  localparam logic [1:0] c_OP_LR    = 2'b10;
  localparam logic [1:0] c_OP_SC    = 2'b11;

  localparam logic [TMR_W-1:0] c_TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] c_TMR_ONE  = TMR_W'(1);

  logic              rsp_valid_q;
  logic [HART_W-1:0] rsp_hart_q;
  logic [1:0]        rsp_op_q;
  logic              rsp_fail_q;

  logic              w_fire;
  logic [GRAN_W-1:0] w_req_gran;
  logic [GRAN_W-1:0] w_snp_gran;
  logic              w_snoop_same;
  logic              w_is_store;
  logic              w_is_lr;
  logic              w_is_sc;
  logic              w_sc_pass;

  logic [NUM_HARTS-1:0] w_match_req;
  logic [NUM_HARTS-1:0] w_own;

  // A request is never accepted while reset is held, even with a free buffer.
  assign o_req_ready  = !i_rst && (!rsp_valid_q || i_rsp_ready);
  assign w_fire       = i_req_valid && o_req_ready;

  assign w_req_gran   = i_req_addr[XLEN-1:GRANULE_BITS];
  assign w_snp_gran   = i_snoop_addr[XLEN-1:GRANULE_BITS];
  assign w_snoop_same = i_snoop_valid && (w_snp_gran == w_req_gran);

  assign w_is_store   = w_fire && (i_req_op == c_OP_STORE);
  assign w_is_lr      = w_fire && (i_req_op == c_OP_LR);
  assign w_is_sc      = w_fire && (i_req_op == c_OP_SC);

  // A snoop to the same granule is ordered ahead of the SC and kills it.
  assign w_sc_pass    = (|(w_match_req & w_own)) && !w_snoop_same;

  generate
    if (GRANULE_BITS > 0) begin : g_lowbits
      logic w_unused_low_bits;
      assign w_unused_low_bits = ^{i_req_addr[GRANULE_BITS-1:0],
                                   i_snoop_addr[GRANULE_BITS-1:0]};
    end
  endgenerate

  generate
    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_entry
      logic              valid_q, valid_d;
      logic [GRAN_W-1:0] addr_q, addr_d;
      logic [TMR_W-1:0]  timer_q, timer_d;
      logic              snoop_hit;

      assign w_own[h]       = (i_req_hart == HART_W'(h));
      assign w_match_req[h] = valid_q && (addr_q == w_req_gran);
      assign snoop_hit      = i_snoop_valid && valid_q && (addr_q == w_snp_gran);
      assign o_res_valid[h] = valid_q;

      // Lowest priority first; later assignments win.
      always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        timer_d = timer_q;
        if (valid_q) begin
          timer_d = timer_q - c_TMR_ONE;
          if (timer_q == c_TMR_ONE) valid_d = 1'b0;
        end
        if (snoop_hit) valid_d = 1'b0;
        if (w_is_store && w_match_req[h]) valid_d = 1'b0;
        if (w_is_sc && w_sc_pass && w_match_req[h]) valid_d = 1'b0;
        if (w_is_sc && w_own[h]) valid_d = 1'b0;
        if (w_is_lr && w_own[h]) begin
          valid_d = 1'b1;
          addr_d  = w_req_gran;
          timer_d = c_TMR_LOAD;
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          valid_q <= 1'b0;
          addr_q  <= '0;
          timer_q <= '0;
        end else begin
          valid_q <= valid_d;
          addr_q  <= addr_d;
          timer_q <= timer_d;
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_valid_q <= 1'b0;
      rsp_hart_q  <= '0;
      rsp_op_q    <= c_OP_LOAD;
      rsp_fail_q  <= 1'b0;
    end else if (w_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_hart_q  <= i_req_hart;
      rsp_op_q    <= i_req_op;
      rsp_fail_q  <= (i_req_op == c_OP_SC) && !w_sc_pass;
    end else if (i_rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_hart    = rsp_hart_q;
  assign o_rsp_op      = rsp_op_q;
  assign o_rsp_sc_fail = rsp_fail_q;

endmodule

`default_nettype wire

// File: tb/tb_lr_sc_responder.sv
// ============================================================================
// tb_lr_sc_responder : directed self-checking bench for lr_sc_responder
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_lr_sc_responder;

  localparam logic [1:0] c_LD = 2'b00;
  localparam logic [1:0] c_ST = 2'b01;
  localparam logic [1:0] c_LR = 2'b10;
  localparam logic [1:0] c_SC = 2'b11;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [0:0]  i_req_hart;
  logic [1:0]  i_req_op;
  logic [31:0] i_req_addr;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [0:0]  o_rsp_hart;
  logic [1:0]  o_rsp_op;
  logic        o_rsp_sc_fail;
  logic        i_snoop_valid;
  logic [31:0] i_snoop_addr;
  logic [1:0]  o_res_valid;

  int n_chk  = 0;
  int n_pass = 0;

  lr_sc_responder #(
    .XLEN(32), .NUM_HARTS(2), .HART_W(1), .GRANULE_BITS(2), .TIMEOUT_CYCLES(64)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_hart(i_req_hart), .i_req_op(i_req_op), .i_req_addr(i_req_addr),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_hart(o_rsp_hart), .o_rsp_op(o_rsp_op), .o_rsp_sc_fail(o_rsp_sc_fail),
    .i_snoop_valid(i_snoop_valid), .i_snoop_addr(i_snoop_addr),
    .o_res_valid(o_res_valid)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One request in one cycle, optionally with a concurrent snoop.
  task automatic fire(input logic [0:0] h, input logic [1:0] op, input logic [31:0] a,
                      input logic sv, input logic [31:0] sa);
    i_req_valid   = 1'b1;
    i_req_hart    = h;
    i_req_op      = op;
    i_req_addr    = a;
    i_snoop_valid = sv;
    i_snoop_addr  = sa;
    step();
    i_req_valid   = 1'b0;
    i_snoop_valid = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_req_valid = 1'b1; i_req_hart = '0; i_req_op = c_LR;
    i_req_addr = 32'h100; i_rsp_ready = 1'b1; i_snoop_valid = 1'b0; i_snoop_addr = '0;

    // Reset with a request pending: nothing may be accepted.
    #1;
    check("rst_req_ready", 32'(o_req_ready), 32'd0);
    step();
    check("rst_req_ready_2", 32'(o_req_ready), 32'd0);
    step();
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_res_valid", 32'(o_res_valid), 32'd0);
    i_rst = 1'b0; i_req_valid = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(o_req_ready), 32'd1);
    check("post_rst_fields", {28'd0, o_rsp_hart, o_rsp_op, o_rsp_sc_fail}, 32'd0);

    // LR then back-to-back SC passes; second SC fails.
    fire(1'b0, c_LR, 32'h100, 1'b0, 32'h0);
    check("lr_rsp_valid", 32'(o_rsp_valid), 32'd1);
    check("lr_rsp_op", 32'(o_rsp_op), 32'(c_LR));
    check("lr_res_valid", 32'(o_res_valid), 32'b01);
    fire(1'b0, c_SC, 32'h100, 1'b0, 32'h0);
    check("sc1_fail", 32'(o_rsp_sc_fail), 32'd0);
    check("sc1_op", 32'(o_rsp_op), 32'(c_SC));
    check("sc1_res_valid", 32'(o_res_valid), 32'b00);
    fire(1'b0, c_SC, 32'h100, 1'b0, 32'h0);
    check("sc2_fail", 32'(o_rsp_sc_fail), 32'd1);

    // Conflicting store from the other hart in the same granule.
    fire(1'b0, c_LR, 32'h100, 1'b0, 32'h0);
    fire(1'b1, c_ST, 32'h102, 1'b0, 32'h0);
    check("st_same_fail", 32'(o_rsp_sc_fail), 32'd0);
    check("st_same_hart", 32'(o_rsp_hart), 32'd1);
    check("st_same_res", 32'(o_res_valid), 32'b00);
    fire(1'b0, c_SC, 32'h100, 1'b0, 32'h0);
    check("sc_after_st_same", 32'(o_rsp_sc_fail), 32'd1);
    fire(1'b0, c_LR, 32'h100, 1'b0, 32'h0);
    fire(1'b1, c_ST, 32'h104, 1'b0, 32'h0);
    check("st_other_res", 32'(o_res_valid), 32'b01);
    fire(1'b0, c_SC, 32'h100, 1'b0, 32'h0);
    check("sc_after_st_other", 32'(o_rsp_sc_fail), 32'd0);

    // SC pass by h1 kills h0's reservation on the same granule.
    fire(1'b0, c_LR, 32'h200, 1'b0, 32'h0);
    fire(1'b1, c_LR, 32'h200, 1'b0, 32'h0);
    check("two_lr_res", 32'(o_res_valid), 32'b11);
    fire(1'b1, c_SC, 32'h200, 1'b0, 32'h0);
    check("sc_h1_fail", 32'(o_rsp_sc_fail), 32'd0);
    check("sc_h1_res", 32'(o_res_valid), 32'b00);
    fire(1'b0, c_SC, 32'h200, 1'b0, 32'h0);
    check("sc_h0_after_h1", 32'(o_rsp_sc_fail), 32'd1);

    // Lifetime: LR in cycle 0, SC in cycle 64 passes.
    fire(1'b0, c_LR, 32'h240, 1'b0, 32'h0);
    for (int i = 0; i < 63; i++) step();
    check("tmo_res_c64", 32'(o_res_valid), 32'b01);
    fire(1'b0, c_SC, 32'h240, 1'b0, 32'h0);
    check("tmo_sc_c64", 32'(o_rsp_sc_fail), 32'd0);
    // Rerun: SC in cycle 65 fails.
    fire(1'b0, c_LR, 32'h240, 1'b0, 32'h0);
    for (int i = 0; i < 64; i++) step();
    check("tmo_res_c65", 32'(o_res_valid), 32'b00);
    fire(1'b0, c_SC, 32'h240, 1'b0, 32'h0);
    check("tmo_sc_c65", 32'(o_rsp_sc_fail), 32'd1);

    // Snoop interactions.
    fire(1'b0, c_LR, 32'h300, 1'b0, 32'h0);
    fire(1'b0, c_SC, 32'h300, 1'b1, 32'h301);
    check("snoop_sc_fail", 32'(o_rsp_sc_fail), 32'd1);
    check("snoop_sc_res", 32'(o_res_valid), 32'b00);
    fire(1'b0, c_LR, 32'h300, 1'b1, 32'h300);
    check("snoop_lr_res", 32'(o_res_valid), 32'b01);
    fire(1'b1, c_LD, 32'h300, 1'b1, 32'h500);
    check("load_op", 32'(o_rsp_op), 32'(c_LD));
    check("load_fail", 32'(o_rsp_sc_fail), 32'd0);
    check("load_res", 32'(o_res_valid), 32'b01);
    i_snoop_valid = 1'b1; i_snoop_addr = 32'h303;
    step();
    i_snoop_valid = 1'b0;
    check("snoop_only_res", 32'(o_res_valid), 32'b00);

    // Backpressure: hold the LR response for three cycles.
    step();
    i_rsp_ready = 1'b0;
    fire(1'b1, c_LR, 32'h400, 1'b0, 32'h0);
    i_req_valid = 1'b1; i_req_hart = 1'b1; i_req_op = c_SC; i_req_addr = 32'h400;
    for (int i = 0; i < 3; i++) begin
      check("bp_req_ready", 32'(o_req_ready), 32'd0);
      check("bp_rsp", {27'd0, o_rsp_valid, o_rsp_hart, o_rsp_op, o_rsp_sc_fail},
            {27'd0, 1'b1, 1'b1, c_LR, 1'b0});
      step();
    end
    i_rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(o_req_ready), 32'd1);
    step();
    i_req_valid = 1'b0;
    check("bp_sc_op", 32'(o_rsp_op), 32'(c_SC));
    check("bp_sc_fail", 32'(o_rsp_sc_fail), 32'd0);

    // Reset during a held response drops it.
    i_rsp_ready = 1'b0;
    fire(1'b0, c_LD, 32'h10, 1'b0, 32'h0);
    step();
    check("hold_before_rst", 32'(o_rsp_valid), 32'd1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("rst_mid_hold", 32'(o_rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
